// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register bank: NUM_RD read ports, two prioritised write
// ports, a link-write path and a per-register load-pending scoreboard.
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = 31,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     link_en,
    input  logic [DATA_W-1:0]        link_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    output logic [ADDR_W:0]          pending_cnt
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] ZERO_A = '0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic [ADDR_W:0]   cnt_nxt;

    logic a_commit;
    logic b_commit;
    logic l_commit;

    // Resolve which writes actually land this edge (A > B > link, r0 immune)
    always_comb begin
        a_commit = !reset && wa_en && (wa_addr != ZERO_A);
        b_commit = !reset && wb_en && (wb_addr != ZERO_A)
                   && !(wa_en && (wa_addr == wb_addr));
        l_commit = !reset && link_en && (LINK_A != ZERO_A)
                   && !(wa_en && (wa_addr == LINK_A))
                   && !(wb_en && (wb_addr == LINK_A));
    end

    // Register storage; commit addresses are distinct by construction
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (a_commit) begin
                regs[wa_addr] <= wa_data;
            end
            if (b_commit) begin
                regs[wb_addr] <= wb_data;
            end
            if (l_commit) begin
                regs[LINK_A] <= link_data;
            end
        end
    end

    // Next pending vector: writeback clears, load issue sets (set wins)
    always_comb begin
        pending_nxt = pending;
        if (wb_en) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (sb_set_en) begin
            pending_nxt[sb_set_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Population count of the next pending vector
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
        end
    end

    // Scoreboard state and its registered population count
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] val;

            assign addr = rd_addr[k*ADDR_W +: ADDR_W];

            // Read mux: stored value, optionally overridden by this edge's write
            always_comb begin
                val = regs[addr];
                if (BYPASS) begin
                    if (a_commit && (wa_addr == addr)) begin
                        val = wa_data;
                    end else if (b_commit && (wb_addr == addr)) begin
                        val = wb_data;
                    end else if (l_commit && (LINK_A == addr)) begin
                        val = link_data;
                    end
                end
                if (addr == ZERO_A) begin
                    val = '0;
                end
            end

            assign rd_data[k*DATA_W +: DATA_W] = val;

            assign rd_busy[k] = pending[addr]
                                && !(wb_en && (wb_addr == addr)
                                     && (addr != ZERO_A));
        end
    endgenerate

endmodule
